// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair.
//   - uart_state_e      : frame state encoding (idle, start, data, parity, stop)
//   - PAR_NONE/ODD/EVEN : parity mode codes used by the PARITY parameter
//   - calc_clks_per_bit : clock cycles per serial bit, truncated
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0; tick_o is high for
// the single cycle in which the count sits at CLKS_PER_BIT-1.
// Ports:
//   clk_i    in  system clock, rising edge
//   nreset_i in  asynchronous active-low reset
//   clr_i    in  restart the bit period at 0 (wins over en_i)
//   en_i     in  count enable
//   tick_o   out last cycle of the current bit period
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_o = en_i && (cnt == LAST);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= tick_o ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as start bit,
// 8 data bits LSB first, optional parity bit and 1 or 2 stop bits.
// Ports:
//   clk_i    in  system clock, rising edge
//   nreset_i in  asynchronous active-low reset
//   valid_i  in  byte on data_i is offered
//   ready_o  out transmitter accepts a byte this cycle
//   data_i   in  byte to send
//   tx_o     out serial line, idle high, registered
//   busy_o   out frame in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  uart_state_e state;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic        armed;     // low only until the first edge after reset release
  logic [7:0]  shift;
  logic        par_bit;
  logic        tick;
  logic        xfer;
  logic        last_stop_bit;
  logic        frame_end;

  function automatic logic parity_of(input logic [7:0] b);
    return (PARITY == PAR_EVEN) ? ^b : ~^b;
  endfunction

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .clr_i   (xfer),
    .en_i    (state != ST_IDLE),
    .tick_o  (tick)
  );

  assign last_stop_bit = (STOP_BITS == 2) ? stop_idx : 1'b1;
  // Final clock of the last stop bit: a new byte may be accepted here so
  // consecutive frames run with no idle gap.
  assign frame_end = (state == ST_STOP) && tick && last_stop_bit;
  assign ready_o   = armed && ((state == ST_IDLE) || frame_end);
  assign xfer      = valid_i && ready_o;
  assign busy_o    = (state != ST_IDLE);

  // Control path and line output
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state    <= ST_IDLE;
      tx_o     <= 1'b1;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (xfer) begin
        state    <= ST_START;
        tx_o     <= 1'b0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else if (tick) begin
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            tx_o    <= shift[0];
            bit_idx <= '0;
          end
          ST_DATA: begin
            if (bit_idx == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                tx_o  <= par_bit;
              end else begin
                state <= ST_STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              // shift[1] is the bit that becomes shift[0] at this edge
              tx_o    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
            tx_o  <= 1'b1;
          end
          ST_STOP: begin
            if (last_stop_bit) begin
              state <= ST_IDLE;
              tx_o  <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            tx_o  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Data path: byte and its parity captured at the handshake
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      shift   <= data_i;
      par_bit <= parity_of(data_i);
    end else if (tick && (state == ST_DATA) && (bit_idx != 3'd7)) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter. Accepts one byte per valid/ready handshake and shifts it out on `tx_o` as start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop bits. It sits between the byte-stream producer and the pad, and is the transmit counterpart of `uart_rx`, using the same frame format and baud timing.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s; `CLKS_PER_BIT` = `CLK_FREQ`/`BAUD_RATE`, truncated (10416 at defaults). Must be ≥ 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

- `clk_i`  in  1  system clock, rising edge.
- `nreset_i`  in  1  reset, asynchronous assert, active-low.
- `valid_i`  in  1  byte on `data_i` is offered.
- `ready_o`  out  1  transmitter can accept a byte this cycle.
- `data_i`  in  8  byte to send.
- `tx_o`  out  1  serial line, idle high, registered.
- `busy_o`  out  1  frame in progress (not IDLE).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Transfer: occurs on a rising edge with `valid_i && ready_o`. `data_i` is captured into the shift register, and parity is computed from the captured byte at the same edge. Later changes on `data_i` have no effect.
- `valid_i` while `ready_o`=0 is ignored; no pending request is stored.
- IDLE: `tx_o`=1. On transfer, go to START.
- START: `tx_o`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: `tx_o`=shift[0] for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After bit 7, go to PARITY if `PARITY`≠0, otherwise go to STOP.
- PARITY: even sends XOR of the byte; odd sends its inverse. Lasts `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `tx_o`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then go to IDLE.
- Back-to-back frames: `ready_o` is also asserted in the final clock of the last stop bit. A transfer in that cycle goes straight to START with no idle cycle between frames. With no transfer, go to IDLE.
- Baud counter: width clog2(`CLKS_PER_BIT`). Counts 0..`CLKS_PER_BIT`−1 and wraps to 0 at each bit boundary. It is cleared on transfer, so every bit lasts exactly `CLKS_PER_BIT` cycles.

## Timing
- Reset values: `tx_o`=1, `ready_o`=0, `busy_o`=0, state=IDLE, counters=0. `ready_o` rises on the first rising edge after `nreset_i` deasserts.
- Latency: `tx_o` falls at the edge that performs the transfer, i.e. visible in the cycle after the handshake.
- Frame length: (1 + 8 + (`PARITY`≠0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles. At defaults with no parity this is 104160 cycles.
- `ready_o` is high in IDLE and in the last cycle of the last stop bit, and low in all other cycles.
- `busy_o` is high from the edge after the transfer until entry to IDLE. It stays high across back-to-back frames.
- Reset mid-frame: `tx_o` goes to 1 asynchronously. After release the block is in IDLE with no residual frame and no truncated start bit is emitted.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE..STOP);
  - the parity mode constants (NONE, ODD, EVEN);
  - the `CLKS_PER_BIT` computation function.
- `uart_rx` uses the same package.
- Sub-module `uart_baud_cnt` is the bit-period counter with a clear input and a one-cycle `tick_o` at count `CLKS_PER_BIT`−1. It is reusable by `uart_rx`.

## Test plan
- Single byte, defaults, `PARITY`=0: send 0x95. `tx_o` must be 0,1,0,1,0,1,0,0,1,1, each level held exactly 10416 cycles. `ready_o` must be low for 104159 cycles.
- Parity: `CLK_FREQ`=1000, `BAUD_RATE`=100 (10 clk/bit), byte 0x95. With `PARITY`=2 the parity bit must be 0; with `PARITY`=1 it must be 1. With `STOP_BITS`=2 the stop level must last 20 cycles.
- Back-to-back: hold `valid_i` with bytes 0x95 then 0x3C. The second start bit must begin on the cycle right after the first frame's stop bit, with zero idle cycles, and `busy_o` must never drop.
- Ignored request: pulse `valid_i` with 0xFF during the DATA state of a 0x95 frame. The frame must be unchanged and no second frame may be sent.
- Reset mid-frame: assert `nreset_i`=0 during data bit 3. `tx_o` must go to 1 without waiting for a clock edge. After release, `ready_o`=1 after one edge, and a new 0x5A frame must be sent correctly.
- Loopback: connect `tx_o` to `uart_rx` `rx_i` at defaults and send 0x95 then 0x01. `uart_rx` `data_o` must report 0x95 then 0x01.
